// File: rtl/mod_counter_pkg.sv
// mod_counter shared definitions.
// Direction/mode encodings and FSM state type.
package mod_counter_pkg;

    localparam logic DIR_DOWN     = 1'b0;
    localparam logic DIR_UP       = 1'b1;
    localparam logic MODE_RELOAD  = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef enum logic {
        COUNT = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/mod_counter_if.sv
// mod_counter control/status bundle.
// master drives controls, slave is the counter.
interface mod_counter_if #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
);

    logic                  enable;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic                  dir;
    logic                  mode;
    logic [WIDTH-1:0]      terminal;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  done;

    modport master (
        output enable, load, load_value, dir, mode, terminal, prescale,
        input  count, tc, done
    );

    modport slave (
        input  enable, load, load_value, dir, mode, terminal, prescale,
        output count, tc, done
    );

endinterface

// File: rtl/mod_counter_tick_prescaler.sv
// Divides enabled cycles by prescale+1.
// tick is combinational on the wrapping cycle.
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == prescale);

    // divider phase: clear on load, wrap on tick, step when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (clr || tick) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Programmable modulus up/down counter with prescaler,
// auto-reload or one-shot, and a one-cycle tc pulse.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input logic         clk,
    input logic         reset,
    mod_counter_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             tick;
    logic             term_hit;

    // the prescaler is frozen (at 0) while holding
    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.enable && (state_q == COUNT)),
        .clr      (bus.load),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    assign term_hit = (bus.dir == DIR_UP) ? (count_q == bus.terminal)
                                          : (count_q == '0);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= COUNT;
        else       state_q <= state_d;
    end

    // next state: one-shot expiry enters HOLD, only load leaves it
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = COUNT;
        end else if (state_q == COUNT && tick && term_hit
                     && bus.mode == MODE_ONESHOT) begin
            state_d = HOLD;
        end
    end

    // next count/tc/done; load outranks a coincident tick
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (bus.load) begin
            count_d = bus.load_value;
            done_d  = 1'b0;
        end else if (state_q == COUNT && tick) begin
            if (term_hit) begin
                tc_d = 1'b1;
                if (bus.mode == MODE_RELOAD) begin
                    count_d = (bus.dir == DIR_UP) ? '0 : bus.terminal;
                end else begin
                    done_d = 1'b1;
                end
            end else if (bus.dir == DIR_UP) begin
                // above terminal (after load/terminal change): silent wrap
                count_d = (count_q > bus.terminal) ? '0
                                                   : count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule
